leds7_cmd_decoder: RTL and testbench

LEDS7_CMD_DECODER -- requirements
Module: leds7_cmd_decoder

---
 rtl/leds7_cmd_decoder_if.sv | 7 +
 rtl/leds7_cmd_decoder.sv | 87 ++++++++
 tb/tb_leds7_cmd_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/leds7_cmd_decoder_if.sv
// leds7_cmd_decoder_if: byte stream from the UART receive stage, strobe-qualified, no backpressure.
interface leds7_cmd_decoder_if;
  logic [7:0] tdata;
  logic       tvalid;
  modport master (output tdata, tvalid);
  modport slave  (input  tdata, tvalid);
endinterface

// File: rtl/leds7_cmd_decoder.sv
// leds7_cmd_decoder: parses A5/addr/data[/csum] frames into per-digit hex and decimal-point registers.
// Defining LEDS7_CMD_CHECKSUM_EN adds the trailing checksum byte (A5 ^ addr ^ data) to each frame.
module leds7_cmd_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_FREQ   = 50,
  parameter int TIMEOUT_US = 1000
) (
  input  logic                    clk,
  input  logic                    resetn,
  leds7_cmd_decoder_if.slave      rx,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic                    upd,
  output logic                    frame_err,
  output logic [7:0]              err_cnt
);
  localparam int TO_CYC = CLK_FREQ * TIMEOUT_US;
  localparam int CW     = $clog2(TO_CYC + 1);
`ifdef LEDS7_CMD_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif
  state_t        state;
  logic [7:0]    addr;
  logic [CW-1:0] cnt;
  logic          timeout, addr_bad, commit, err_now, cdp;
  logic [3:0]    cval;
`ifdef LEDS7_CMD_CHECKSUM_EN
  logic [7:0]    data;
  assign commit  = rx.tvalid && state == CSUM && rx.tdata == (8'hA5 ^ addr ^ data);
  assign err_now = timeout || addr_bad || (rx.tvalid && state == CSUM && !commit);
  assign cval    = data[3:0];
  assign cdp     = data[7];
`else
  assign commit  = rx.tvalid && state == DATA;
  assign err_now = timeout || addr_bad;
  assign cval    = rx.tdata[3:0];
  assign cdp     = rx.tdata[7];
`endif
  // cnt is 0 after the sampling edge, so this edge lands frame_err TO_CYC cycles after the byte's tvalid cycle
  assign timeout  = state != IDLE && !rx.tvalid && cnt == CW'(TO_CYC - 2);
  assign addr_bad = rx.tvalid && state == ADDR && rx.tdata >= 8'(NUM_DIGITS);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      digits    <= '0;
      dp        <= '0;
      upd       <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
`ifdef LEDS7_CMD_CHECKSUM_EN
      data      <= '0;
`endif
    end else begin
      upd       <= commit;
      frame_err <= err_now;
      if (err_now && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      cnt <= (rx.tvalid || state == IDLE) ? '0 : cnt + 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (commit && addr == 8'(i)) begin
          digits[4*i +: 4] <= cval;
          dp[i]            <= cdp;
        end
      if (timeout) state <= IDLE;
      else if (rx.tvalid)
        case (state)
          IDLE: state <= rx.tdata == 8'hA5 ? ADDR : IDLE;
          ADDR: begin
            addr  <= rx.tdata;
            state <= addr_bad ? IDLE : DATA;
          end
`ifdef LEDS7_CMD_CHECKSUM_EN
          DATA: begin
            data  <= rx.tdata;
            state <= CSUM;
          end
`else
          DATA: state <= IDLE;
`endif
          default: state <= IDLE;
        endcase
    end
  end
endmodule

// File: tb/tb_leds7_cmd_decoder.sv
// tb_leds7_cmd_decoder: directed frame tests for leds7_cmd_decoder; honours LEDS7_CMD_CHECKSUM_EN.
module tb_leds7_cmd_decoder;
  localparam int ND = 4;
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp;
  logic          upd, frame_err;
  logic [7:0]    err_cnt;
  int            n_checks = 0;
  int            n_fail = 0;
  int            exp_err = 0;
  leds7_cmd_decoder_if rx ();
  leds7_cmd_decoder #(.NUM_DIGITS(ND), .CLK_FREQ(50), .TIMEOUT_US(1)) dut (
    .clk(clk), .resetn(resetn), .rx(rx), .digits(digits), .dp(dp),
    .upd(upd), .frame_err(frame_err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic send_byte(input logic [7:0] b);
    rx.tdata = b;
    rx.tvalid = 1'b1;
    @(posedge clk); #1;
    rx.tvalid = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
`ifdef LEDS7_CMD_CHECKSUM_EN
    send_byte(8'hA5 ^ a ^ d);
`endif
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (digits !== 16'h0) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", digits); end n_checks++;
    if (dp !== 4'h0) begin n_fail++; $display("FAIL reset_dp: got %b want 0000", dp); end n_checks++;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %b want 0", upd); end n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end n_checks++;
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end n_checks++;
    resetn = 1'b1;
  endtask
  task automatic test_commit();
    send_byte(8'hA5);
    send_byte(8'h02);
`ifdef LEDS7_CMD_CHECKSUM_EN
    send_byte(8'h8C);
    if (upd !== 1'b0) begin n_fail++; $display("FAIL commit_early_upd: got %b want 0", upd); end n_checks++;
    send_byte(8'h2B);
`else
    send_byte(8'h8C);
`endif
    if (upd !== 1'b1) begin n_fail++; $display("FAIL commit_upd: got %b want 1", upd); end n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL commit_frame_err: got %b want 0", frame_err); end n_checks++;
    if (digits !== 16'h0C00) begin n_fail++; $display("FAIL commit_digits: got %h want 0c00", digits); end n_checks++;
    if (dp !== 4'b0100) begin n_fail++; $display("FAIL commit_dp: got %b want 0100", dp); end n_checks++;
    @(posedge clk); #1;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL commit_upd_pulse: got %b want 0", upd); end n_checks++;
  endtask
`ifdef LEDS7_CMD_CHECKSUM_EN
  task automatic test_bad_csum();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h07);
    send_byte(8'h00);
    exp_err++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL csum_frame_err: got %b want 1", frame_err); end n_checks++;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL csum_upd: got %b want 0", upd); end n_checks++;
    if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL csum_err_cnt: got %0d want %0d", err_cnt, exp_err); end n_checks++;
    if (digits !== 16'h0C00) begin n_fail++; $display("FAIL csum_digits: got %h want 0c00", digits); end n_checks++;
    @(posedge clk); #1;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL csum_err_pulse: got %b want 0", frame_err); end n_checks++;
  endtask
`endif
  task automatic test_bad_addr();
    send_byte(8'hA5);
    send_byte(8'h05);
    exp_err++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL addr_frame_err: got %b want 1", frame_err); end n_checks++;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL addr_upd: got %b want 0", upd); end n_checks++;
    if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL addr_err_cnt: got %0d want %0d", err_cnt, exp_err); end n_checks++;
    send_byte(8'h07);
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL addr_ignored_err: got %b want 0", frame_err); end n_checks++;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL addr_ignored_upd: got %b want 0", upd); end n_checks++;
    send_frame(8'h00, 8'h83);
    if (upd !== 1'b1) begin n_fail++; $display("FAIL addr_resync_upd: got %b want 1", upd); end n_checks++;
    if (digits !== 16'h0C03) begin n_fail++; $display("FAIL addr_resync_digits: got %h want 0c03", digits); end n_checks++;
    if (dp !== 4'b0101) begin n_fail++; $display("FAIL addr_resync_dp: got %b want 0101", dp); end n_checks++;
  endtask
  task automatic test_timeout();
    int n;
    send_byte(8'hA5);
    send_byte(8'h01);
    // tvalid cycle of 01 is cycle 0; we are now in cycle 1, frame_err belongs in cycle 50
    n = 0;
    while (frame_err !== 1'b1 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    exp_err++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL timeout_seen: got %b want 1 within 80 cycles", frame_err); end n_checks++;
    if (n !== 49) begin n_fail++; $display("FAIL timeout_cycle: got cycle %0d want 50", n + 1); end n_checks++;
    if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL timeout_err_cnt: got %0d want %0d", err_cnt, exp_err); end n_checks++;
    @(posedge clk); #1;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b want 0", frame_err); end n_checks++;
    send_frame(8'h01, 8'h05);
    if (upd !== 1'b1) begin n_fail++; $display("FAIL timeout_idle_upd: got %b want 1", upd); end n_checks++;
    if (digits !== 16'h0C53) begin n_fail++; $display("FAIL timeout_idle_digits: got %h want 0c53", digits); end n_checks++;
  endtask
  task automatic test_timeout_coincide();
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (48) @(posedge clk);
    #1;
    send_byte(8'h0A);
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL coincide_frame_err: got %b want 0", frame_err); end n_checks++;
`ifdef LEDS7_CMD_CHECKSUM_EN
    send_byte(8'hAE);
`endif
    if (upd !== 1'b1) begin n_fail++; $display("FAIL coincide_upd: got %b want 1", upd); end n_checks++;
    if (digits !== 16'h0CA3) begin n_fail++; $display("FAIL coincide_digits: got %h want 0ca3", digits); end n_checks++;
    if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL coincide_err_cnt: got %0d want %0d", err_cnt, exp_err); end n_checks++;
  endtask
  task automatic test_back_to_back();
    send_frame(8'h03, 8'h09);
    if (upd !== 1'b1) begin n_fail++; $display("FAIL b2b_upd1: got %b want 1", upd); end n_checks++;
    if (digits !== 16'h9CA3) begin n_fail++; $display("FAIL b2b_digits1: got %h want 9ca3", digits); end n_checks++;
    if (dp !== 4'b0101) begin n_fail++; $display("FAIL b2b_dp1: got %b want 0101", dp); end n_checks++;
    send_frame(8'h00, 8'h7F);
    if (upd !== 1'b1) begin n_fail++; $display("FAIL b2b_upd2: got %b want 1", upd); end n_checks++;
    if (digits !== 16'h9CAF) begin n_fail++; $display("FAIL b2b_digits2: got %h want 9caf", digits); end n_checks++;
    if (dp !== 4'b0100) begin n_fail++; $display("FAIL b2b_dp2: got %b want 0100", dp); end n_checks++;
  endtask
  task automatic test_reset_midframe();
    send_byte(8'hA5);
    send_byte(8'h03);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_err = 0;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end n_checks++;
    if (digits !== 16'h0) begin n_fail++; $display("FAIL rstmid_digits_cleared: got %h want 0000", digits); end n_checks++;
    send_frame(8'h03, 8'h04);
    if (upd !== 1'b1) begin n_fail++; $display("FAIL rstmid_upd: got %b want 1", upd); end n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err_after: got %b want 0", frame_err); end n_checks++;
    if (digits !== 16'h4000) begin n_fail++; $display("FAIL rstmid_digits: got %h want 4000", digits); end n_checks++;
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_err_cnt: got %0d want 0", err_cnt); end n_checks++;
  endtask
  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5);
      send_byte(8'h05);
      exp_err++;
      if (i == 253 && err_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", err_cnt); end
      if (i == 253) n_checks++;
    end
    if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255 after %0d errors", err_cnt, exp_err); end n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL sat_pulse: got %b want 1", frame_err); end n_checks++;
  endtask
  initial begin
    rx.tdata = 8'h00;
    rx.tvalid = 1'b0;
    test_reset();
    test_commit();
`ifdef LEDS7_CMD_CHECKSUM_EN
    test_bad_csum();
`endif
    test_bad_addr();
    test_timeout();
    test_timeout_coincide();
    test_back_to_back();
    test_reset_midframe();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
